// File: rtl/pipe_haz_pkg.sv
// pipe_haz_pkg -- shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t   : operand forward select encoding
//   haz_state_t : memory-wait state machine encoding
//   reg_match   : true when two register indices match and are not x0
package pipe_haz_pkg;

  // Widest register index reg_match accepts; callers zero-extend their indices.
  localparam int unsigned MAX_AW = 16;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } haz_state_t;

  function automatic logic reg_match(input logic [MAX_AW-1:0] a,
                                     input logic [MAX_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/haz_fwd_sel.sv
// haz_fwd_sel -- forward select for one E-stage source operand.
// Ports:
//   rs_e         in  AW  source index in E
//   rd_m, rd_w   in  AW  destination indices in M and W
//   reg_write_m  in  1   M instruction writes the register file
//   reg_write_w  in  1   W instruction writes the register file
//   fwd_sel      out 2   00 register file, 01 W result, 10 M ALU result
module haz_fwd_sel
  import pipe_haz_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rd_m,
  input  logic [AW-1:0] rd_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output logic [1:0]    fwd_sel
);

  fwd_sel_t sel;

  // M is the younger producer, so it wins over W.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && reg_match(MAX_AW'(rd_m), MAX_AW'(rs_e)))
      sel = FWD_M;
    else if (reg_write_w && reg_match(MAX_AW'(rd_w), MAX_AW'(rs_e)))
      sel = FWD_W;
  end

  assign fwd_sel = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard, forwarding and data-memory wait control for a
// five-stage pipeline. Drives the stage-register enables (stall_*) and
// synchronous clears (flush_d/flush_e), the E-stage operand forward selects,
// and a sticky memory-timeout error.
// Ports:
//   clk, rst (async, active-low)
//   rs1_d/rs2_d, rs1_e/rs2_e, rd_e, rd_m, rd_w       register indices
//   reg_write_m/_w, load_e, redirect_e               pipeline status
//   mem_req_m, mem_ready_m                           M-stage data memory handshake
//   stall_f..stall_w, flush_d, flush_e               stage register control
//   forward_a_e, forward_b_e                         operand forward selects
//   mem_err                                          sticky timeout error
// Optional build macro PIPE_HAZ_PERF_EN adds saturating PERF_W-bit counters
// perf_lu_cnt, perf_redir_cnt and perf_wait_cnt.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | no outstanding wait; a not-ready access freezes the pipe
// MEM_WAIT | M-stage access waiting for ready; counter tracks wait cycles
// ERR      | access timed out; pipe frozen until reset
module pipe_hazard_ctrl
  import pipe_haz_pkg::*;
#(
  parameter int unsigned AW          = 5,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned PERF_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_d,
  input  logic [AW-1:0] rs2_d,
  input  logic [AW-1:0] rs1_e,
  input  logic [AW-1:0] rs2_e,
  input  logic [AW-1:0] rd_e,
  input  logic [AW-1:0] rd_m,
  input  logic [AW-1:0] rd_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  input  logic          load_e,
  input  logic          redirect_e,
  input  logic          mem_req_m,
  input  logic          mem_ready_m,
  output logic          stall_f,
  output logic          stall_d,
  output logic          stall_e,
  output logic          stall_m,
  output logic          stall_w,
  output logic          flush_d,
  output logic          flush_e,
  output logic [1:0]    forward_a_e,
  output logic [1:0]    forward_b_e,
`ifdef PIPE_HAZ_PERF_EN
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_redir_cnt,
  output logic [PERF_W-1:0] perf_wait_cnt,
`endif
  output logic          mem_err
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  haz_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic             mem_err_nxt;
  logic             mem_stall_req;
  logic             mem_hold;
  logic             load_use;
  logic             timeout_hit;

  // ---------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------
  haz_fwd_sel #(.AW(AW)) u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel     (forward_a_e)
  );

  haz_fwd_sel #(.AW(AW)) u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel     (forward_b_e)
  );

  // ---------------------------------------------------------------------
  // Memory wait FSM
  // ---------------------------------------------------------------------
  assign mem_stall_req = mem_req_m && !mem_ready_m;
  assign mem_hold      = mem_stall_req || (state == ERR);

  // Wait cycles completed including the current one. The cycle that first
  // sees a not-ready access in RUN is wait cycle 1. Saturates, never wraps.
  always_comb begin
    if (state == RUN)
      wait_inc = CNT_W'(1);
    else if (wait_cnt == CNT_MAX)
      wait_inc = wait_cnt;
    else
      wait_inc = wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (32'(wait_inc) >= MEM_TIMEOUT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      RUN: begin
        if (mem_stall_req) begin
          wait_cnt_nxt = wait_inc;
          if (timeout_hit) begin
            state_nxt   = ERR;
            mem_err_nxt = 1'b1;
          end else begin
            state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        // Ready is checked first so a ready on the limit cycle is not an error.
        if (mem_ready_m) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_inc;
          if (timeout_hit) begin
            state_nxt   = ERR;
            mem_err_nxt = 1'b1;
          end
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Stall / flush priority: memory freeze, then redirect, then load-use
  // ---------------------------------------------------------------------
  assign load_use = load_e &&
                    (reg_match(MAX_AW'(rd_e), MAX_AW'(rs1_d)) ||
                     reg_match(MAX_AW'(rd_e), MAX_AW'(rs2_d)));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_hold) begin
      // W is frozen too so a value being forwarded from W stays valid.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (redirect_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  // ---------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic lu_act, redir_act, wait_act;

  assign lu_act    = !mem_hold && !redirect_e && load_use;
  assign redir_act = !mem_hold && redirect_e;
  assign wait_act  = mem_hold && (state != ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_cnt    <= '0;
      perf_redir_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (lu_act && (perf_lu_cnt != PERF_MAX))
        perf_lu_cnt <= perf_lu_cnt + PERF_W'(1);
      if (redir_act && (perf_redir_cnt != PERF_MAX))
        perf_redir_cnt <= perf_redir_cnt + PERF_W'(1);
      if (wait_act && (perf_wait_cnt != PERF_MAX))
        perf_wait_cnt <= perf_wait_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised successor to the pipeline's hazard/forwarding unit. It has the same job: operand forwarding, load-use stall and redirect flush. It adds three things: data-memory wait-state handling, with a whole-pipe freeze while the M-stage memory access is not ready; a memory timeout with a sticky error; and optional performance counters. It sits beside the five pipeline-register banks and drives their enable and clear inputs.

Parameters:
AW, 5, register-index width (register count = 2**AW)
MEM_TIMEOUT, 0, maximum consecutive wait cycles before error; 0 disables the timeout
PERF_W, 32, width of each performance counter (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
rs1_d  in  AW  source 1 index, D stage
rs2_d  in  AW  source 2 index, D stage
rs1_e  in  AW  source 1 index, E stage
rs2_e  in  AW  source 2 index, E stage
rd_e  in  AW  destination index, E stage
rd_m  in  AW  destination index, M stage
rd_w  in  AW  destination index, W stage
reg_write_m  in  1  M-stage instruction writes the register file
reg_write_w  in  1  W-stage instruction writes the register file
load_e  in  1  E-stage instruction is a load (result comes from memory)
redirect_e  in  1  taken branch, jal or jalr resolved in E
mem_req_m  in  1  M stage is accessing data memory
mem_ready_m  in  1  data memory completes the access this cycle
stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the corresponding stage register
flush_d, flush_e  out  1 each  synchronous clear of the D and E registers (insert a bubble)
forward_a_e, forward_b_e  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result
mem_err  out  1  sticky memory-timeout error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset value: RUN, wait counter 0, mem_err 0.
- mem_hold = (mem_req_m & ~mem_ready_m) | (state == ERR). It is combinational and takes effect in the same cycle.
- Output priority, all combinational:
  - mem_hold: all five stalls = 1, both flushes = 0. W is also frozen, so a forwarded W value stays valid. The repeated register-file write is idempotent.
  - else redirect_e: flush_d = 1, flush_e = 1, all stalls = 0. A redirect overrides any load-use condition.
  - else load-use (load_e, rd_e != 0, and rd_e == rs1_d or rd_e == rs2_d): stall_f = 1, stall_d = 1, flush_e = 1.
  - else all outputs = 0.
- Load-use stall lasts exactly one cycle. After the bubble the load is in M, and the dependent instruction forwards from W one cycle later.
- Forwarding, per operand x in {a, b}:
  - 10 when reg_write_m & rd_m != 0 & rd_m == rsx_e
  - else 01 when reg_write_w & rd_w != 0 & rd_w == rsx_e
  - else 00
  - M has priority over W. Register 0 is never forwarded. Forwarding is independent of stall and flush.
- Transitions:
  - RUN -> MEM_WAIT when mem_req_m & ~mem_ready_m.
  - MEM_WAIT -> RUN on mem_ready_m, clearing the counter. Otherwise the counter increments.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT while mem_ready_m = 0: go to ERR and set mem_err.
  - A ready arriving in the same cycle as the limit wins: return to RUN, no error.
  - ERR is absorbing until rst; the pipe stays frozen.
- Counter width: $clog2(MEM_TIMEOUT + 1), minimum 1. It never wraps.
- A single-cycle wait (ready on the cycle after the request) costs exactly one frozen cycle.
- Reset asserted mid-wait returns the FSM to RUN immediately. Outputs then follow the inputs combinationally.

Optional Feature:
PIPE_HAZ_PERF_EN
- Defined: adds output ports perf_lu_cnt, perf_redir_cnt and perf_wait_cnt, each PERF_W wide.
  - Each counts cycles in which its branch of the priority chain is active. perf_wait_cnt excludes ERR cycles.
  - Counters saturate at all-ones and reset to 0.
- Not defined: no ports, no counter logic, identical hazard behaviour.

Decomposition:
- Package pipe_haz_pkg contains:
  - fwd_sel_t: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - haz_state_t: RUN, MEM_WAIT, ERR
  - function reg_match(a, b): a == b and a != 0
- Sub-module haz_fwd_sel computes one operand's forward select. It is instantiated twice, once for a and once for b.

Test Plan:
- Forwarding priority: rd_m = rd_w = rs1_e = 7, both reg_write = 1 -> forward_a_e = 10. Clear reg_write_m -> 01. Set rs1_e = 0 with rd_m = rd_w = 0 and both reg_write = 1 -> 00.
- Load-use: load_e = 1, rd_e = 5, rs2_d = 5 -> stall_f = 1, stall_d = 1, flush_e = 1 for one cycle. Same with rd_e = 0 -> no stall.
- Redirect versus load-use in the same cycle: redirect_e = 1 with a load-use hazard -> flush_d = 1, flush_e = 1, stall_f = 0.
- Memory wait: MEM_TIMEOUT = 4, mem_req_m = 1, ready low for 3 cycles -> all stalls = 1 for 3 cycles, no flush, mem_err = 0. On ready -> RUN.
- Timeout: MEM_TIMEOUT = 4, ready never asserted -> mem_err = 1 after 4 wait cycles and stays set. Stalls held until rst = 0, after which mem_err = 0 and state is RUN.
- Memory wait with redirect_e = 1 -> stalls win, flush_d = 0. With PIPE_HAZ_PERF_EN, perf_wait_cnt increments by the number of wait cycles and perf_redir_cnt stays unchanged.
